// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit for the memory stage.
// One Avalon-style transfer per request, with lane steering and load extension.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] eff_addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic [31:0] load_data,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LW  = 6'd34;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LHU = 6'd37;
    localparam logic [5:0] OP_SB  = 6'd40;
    localparam logic [5:0] OP_SH  = 6'd41;
    localparam logic [5:0] OP_SW  = 6'd43;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [5:0]  op_q;
    logic [1:0]  off_q;

    logic        req_ok;
    logic        is_load;
    logic [3:0]  be_n;
    logic [31:0] wd_n;

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ld_n;

    // Decode the incoming request: legality, direction, lanes and steered data.
    always_comb begin
        req_ok  = 1'b0;
        is_load = 1'b1;
        be_n    = 4'b1111;
        wd_n    = store_data;
        case (opcode)
            OP_LB, OP_LBU: begin
                req_ok = 1'b1;
            end
            OP_LH, OP_LHU: begin
                req_ok = ~eff_addr[0];
            end
            OP_LW: begin
                req_ok = (eff_addr[1:0] == 2'b00);
            end
            OP_SB: begin
                req_ok  = 1'b1;
                is_load = 1'b0;
                be_n    = 4'b0001 << eff_addr[1:0];
                wd_n    = {4{store_data[7:0]}};
            end
            OP_SH: begin
                req_ok  = ~eff_addr[0];
                is_load = 1'b0;
                be_n    = eff_addr[1] ? 4'b1100 : 4'b0011;
                wd_n    = {2{store_data[15:0]}};
            end
            OP_SW: begin
                req_ok  = (eff_addr[1:0] == 2'b00);
                is_load = 1'b0;
            end
            default: begin
                req_ok = 1'b0;
            end
        endcase
    end

    // Pick the addressed lane out of the bus word and extend it.
    always_comb begin
        case (off_q)
            2'd1:    sel_byte = readdata[15:8];
            2'd2:    sel_byte = readdata[23:16];
            2'd3:    sel_byte = readdata[31:24];
            default: sel_byte = readdata[7:0];
        endcase
        sel_half = off_q[1] ? readdata[31:16] : readdata[15:0];
        case (op_q)
            OP_LB:   ld_n = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  ld_n = {24'h0, sel_byte};
            OP_LH:   ld_n = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  ld_n = {16'h0, sel_half};
            default: ld_n = readdata;
        endcase
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op_q       <= 6'd0;
            off_q      <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_err   <= 1'b0;
            load_data  <= 32'h0;
            address    <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= opcode;
                        off_q <= eff_addr[1:0];
                        busy  <= 1'b1;
                        if (req_ok) begin
                            state      <= S_BUS;
                            address    <= {eff_addr[31:2], 2'b00};
                            byteenable <= be_n;
                            writedata  <= wd_n;
                            read       <= is_load;
                            write      <= ~is_load;
                        end else begin
                            state     <= S_ERR;
                            done      <= 1'b1;
                            addr_err  <= 1'b1;
                            load_data <= 32'h0;
                        end
                    end
                end
                S_BUS: begin
                    if (!waitrequest) begin
                        state    <= S_DONE;
                        read     <= 1'b0;
                        write    <= 1'b0;
                        done     <= 1'b1;
                        addr_err <= 1'b0;
                        if (read) begin
                            load_data <= ld_n;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    addr_err <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors for the load/store unit.
// Expected values are hand-computed per vector.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] eff_addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic [31:0] load_data;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    int total = 0;
    int bad   = 0;

    mem_access_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .eff_addr   (eff_addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .addr_err   (addr_err),
        .load_data  (load_data),
        .address    (address),
        .read       (read),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .readdata   (readdata),
        .waitrequest(waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one legal access; nw stall cycles; poke pulses start mid-access.
    task automatic xfer(input string tag, input logic [5:0] op,
                        input logic [31:0] ea, input logic [31:0] sd,
                        input logic [31:0] rd, input int nw,
                        input logic is_rd, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] ld,
                        input bit poke);
        opcode      = op;
        eff_addr    = ea;
        store_data  = sd;
        readdata    = 32'h0;
        waitrequest = 1'b1;
        start       = 1'b1;
        tick();
        start      = 1'b0;
        opcode     = 6'd0;
        eff_addr   = 32'hFFFF_FFFF;
        store_data = 32'h0;
        for (int i = 0; i <= nw; i++) begin
            waitrequest = (i < nw);
            readdata    = (i < nw) ? 32'hA5A5_A5A5 : rd;
            if (poke) begin
                start    = 1'b1;
                opcode   = 6'd43;
                eff_addr = 32'h0000_3002;
            end
            chk({tag, " read"}, {31'h0, read}, {31'h0, is_rd});
            chk({tag, " write"}, {31'h0, write}, {31'h0, ~is_rd});
            chk({tag, " addr"}, address, {ea[31:2], 2'b00});
            chk({tag, " be"}, {28'h0, byteenable}, {28'h0, be});
            if (!is_rd) chk({tag, " wdata"}, writedata, wd);
            chk({tag, " busy"}, {31'h0, busy}, 32'h1);
            chk({tag, " early done"}, {31'h0, done}, 32'h0);
            tick();
        end
        start       = 1'b0;
        waitrequest = 1'b0;
        chk({tag, " done"}, {31'h0, done}, 32'h1);
        chk({tag, " err"}, {31'h0, addr_err}, 32'h0);
        chk({tag, " ld"}, load_data, ld);
        chk({tag, " req drop"}, {30'h0, read, write}, 32'h0);
        tick();
        chk({tag, " done clr"}, {31'h0, done}, 32'h0);
        chk({tag, " idle"}, {31'h0, busy}, 32'h0);
    endtask

    // Issue an illegal access; expect an immediate error with no bus activity.
    task automatic xerr(input string tag, input logic [5:0] op,
                        input logic [31:0] ea);
        opcode      = op;
        eff_addr    = ea;
        store_data  = 32'h1111_2222;
        waitrequest = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " done"}, {31'h0, done}, 32'h1);
        chk({tag, " err"}, {31'h0, addr_err}, 32'h1);
        chk({tag, " ld"}, load_data, 32'h0);
        chk({tag, " bus"}, {30'h0, read, write}, 32'h0);
        tick();
        chk({tag, " done clr"}, {31'h0, done}, 32'h0);
        chk({tag, " idle"}, {31'h0, busy}, 32'h0);
        chk({tag, " bus2"}, {30'h0, read, write}, 32'h0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        opcode      = 6'd0;
        eff_addr    = 32'h0;
        store_data  = 32'h0;
        readdata    = 32'h0;
        waitrequest = 1'b0;
        tick();
        tick();
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst err", {31'h0, addr_err}, 32'h0);
        chk("rst rw", {30'h0, read, write}, 32'h0);
        chk("rst be", {28'h0, byteenable}, 32'h0);
        chk("rst addr", address, 32'h0);
        chk("rst wd", writedata, 32'h0);
        chk("rst ld", load_data, 32'h0);
        #2 reset_n = 1'b1;
        tick();

        xfer("lw", 6'd34, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0,
             1'b1, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xfer("lb", 6'd32, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3,
             1'b1, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b0);
        xfer("lbu", 6'd36, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3,
             1'b1, 4'b1111, 32'h0, 32'h0000_0080, 1'b0);
        xfer("lbu1", 6'd36, 32'h0000_1001, 32'h0, 32'h1122_3344, 0,
             1'b1, 4'b1111, 32'h0, 32'h0000_0033, 1'b0);
        xfer("sb", 6'd40, 32'h0000_2002, 32'h1234_56AB, 32'h0, 0,
             1'b0, 4'b0100, 32'hABAB_ABAB, 32'h0000_0033, 1'b0);
        xfer("sh", 6'd41, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1,
             1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0033, 1'b0);
        xfer("sh0", 6'd41, 32'h0000_2000, 32'h0000_1234, 32'h0, 0,
             1'b0, 4'b0011, 32'h1234_1234, 32'h0000_0033, 1'b0);
        xfer("sw", 6'd43, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 2,
             1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0000_0033, 1'b0);

        xerr("lh mis", 6'd33, 32'h0000_3001);
        xerr("sw mis", 6'd43, 32'h0000_3002);
        xerr("op35", 6'd35, 32'h0000_3000);

        xfer("lh hi", 6'd33, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 2,
             1'b1, 4'b1111, 32'h0, 32'hFFFF_8001, 1'b1);
        xfer("lhu lo", 6'd37, 32'h0000_4000, 32'h0, 32'h8001_7FFF, 0,
             1'b1, 4'b1111, 32'h0, 32'h0000_7FFF, 1'b0);
        xfer("lhu hi", 6'd37, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 0,
             1'b1, 4'b1111, 32'h0, 32'h0000_8001, 1'b0);

        opcode      = 6'd34;
        eff_addr    = 32'h0000_5000;
        waitrequest = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre-rst read", {31'h0, read}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst read", {31'h0, read}, 32'h0);
        chk("rst busy2", {31'h0, busy}, 32'h0);
        chk("rst done2", {31'h0, done}, 32'h0);
        waitrequest = 1'b0;
        tick();
        chk("rst hold done", {31'h0, done}, 32'h0);
        #2 reset_n = 1'b1;
        tick();
        chk("post-rst done", {31'h0, done}, 32'h0);

        xfer("lw2", 6'd34, 32'h0000_5008, 32'h0, 32'h1357_9BDF, 1,
             1'b1, 4'b1111, 32'h0, 32'h1357_9BDF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
